// File: rtl/conv_window_addr_gen.sv
`timescale 1ns/1ps
// conv_window_addr_gen: raster sweep of a WIN_H x WIN_W window over NUM_CH row-major planes; CONV_ADDR_PAD_EN adds PAD border.
// First window registered 1 cycle after start, then 1 window/cycle; outputs hold while out_valid & !out_ready, pause stops new windows.
module conv_window_addr_gen #(
    parameter int          IMG_W     = 30,
    parameter int          IMG_H     = 30,
    parameter int          WIN_W     = 5,
    parameter int          WIN_H     = 5,
    parameter int          STRIDE    = 1,
    parameter int          NUM_CH    = 1,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          ADDR_W    = 32,
    parameter int          PAD       = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            pause,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [WIN_H*WIN_W*ADDR_W-1:0]   addr_out,
    output logic [WIN_H*WIN_W-1:0]          tap_mask,
    output logic [15:0]                     win_row,
    output logic [15:0]                     win_col,
    output logic [15:0]                     win_ch,
    output logic                            last,
    output logic                            busy,
    output logic                            done
);
    localparam int NTAP = WIN_H * WIN_W;
`ifdef CONV_ADDR_PAD_EN
    localparam int P = PAD;
`else
    localparam int P = PAD * 0;
`endif
    localparam int OW = (IMG_W + 2 * P - WIN_W) / STRIDE + 1;
    localparam int OH = (IMG_H + 2 * P - WIN_H) / STRIDE + 1;
    localparam logic [ADDR_W-1:0] PLANE     = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [15:0]              row_q, row_d, col_q, col_d, ch_q, ch_d;
    logic                     issued_q, issued_d;
    logic                     out_valid_q, out_valid_d;
    logic [NTAP*ADDR_W-1:0]   addr_q, addr_d;
    logic [NTAP-1:0]          mask_q, mask_d;
    logic [15:0]              win_row_q, win_row_d, win_col_q, win_col_d, win_ch_q, win_ch_d;
    logic                     last_q, last_d;

    logic [NTAP*ADDR_W-1:0]   gen_addr;
    logic [NTAP-1:0]          gen_mask;
    logic                     gen_last;
    logic                     xfer;
    logic                     load;

    // row_q/col_q/ch_q point at the next window to be registered, not the one presented.
    always_comb begin
        int                ty;
        int                tx;
        logic [ADDR_W-1:0] plane_base;
        logic [ADDR_W-1:0] tap_addr;
        gen_addr   = '0;
        gen_mask   = '0;
        ty         = 0;
        tx         = 0;
        plane_base = BASE + ADDR_W'(ch_q) * PLANE;
        tap_addr   = '0;
        for (int r = 0; r < WIN_H; r++) begin
            for (int c = 0; c < WIN_W; c++) begin
                ty       = int'(row_q) * STRIDE - P + r;
                tx       = int'(col_q) * STRIDE - P + c;
                tap_addr = plane_base + ADDR_W'(ty) * ROW_PITCH + ADDR_W'(tx);
`ifdef CONV_ADDR_PAD_EN
                if (ty >= 0 && ty < IMG_H && tx >= 0 && tx < IMG_W) begin
                    gen_addr[(r*WIN_W+c)*ADDR_W +: ADDR_W] = tap_addr;
                    gen_mask[r*WIN_W+c]                    = 1'b1;
                end
`else
                gen_addr[(r*WIN_W+c)*ADDR_W +: ADDR_W] = tap_addr;
                gen_mask[r*WIN_W+c]                    = 1'b1;
`endif
            end
        end
        gen_last = (ch_q == 16'(NUM_CH - 1)) && (row_q == 16'(OH - 1)) && (col_q == 16'(OW - 1));
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        ch_d        = ch_q;
        issued_d    = issued_q;
        out_valid_d = out_valid_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_ch_d    = win_ch_q;
        last_d      = last_q;
        xfer        = out_valid_q & out_ready;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    issued_d = 1'b0;
                    load     = !pause;
                end
            end
            S_RUN: begin
                if (xfer && last_q) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b0;
                    last_d      = 1'b0;
                end else begin
                    load = (!out_valid_q || xfer) && !pause && !issued_q;
                    if (xfer && !load) begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Counters wrap to zero after the final window, so IDLE always points at window 0.
        if (load) begin
            out_valid_d = 1'b1;
            addr_d      = gen_addr;
            mask_d      = gen_mask;
            win_row_d   = row_q;
            win_col_d   = col_q;
            win_ch_d    = ch_q;
            last_d      = gen_last;
            issued_d    = gen_last;
            if (col_q == 16'(OW - 1)) begin
                col_d = '0;
                if (row_q == 16'(OH - 1)) begin
                    row_d = '0;
                    ch_d  = (ch_q == 16'(NUM_CH - 1)) ? 16'd0 : ch_q + 16'd1;
                end else begin
                    row_d = row_q + 16'd1;
                end
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            ch_q        <= '0;
            issued_q    <= 1'b0;
            out_valid_q <= 1'b0;
            addr_q      <= '0;
            mask_q      <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_ch_q    <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ch_q        <= ch_d;
            issued_q    <= issued_d;
            out_valid_q <= out_valid_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_ch_q    <= win_ch_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign addr_out  = addr_q;
    assign tap_mask  = mask_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign win_ch    = win_ch_q;
    assign last      = last_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_window_addr_gen.sv
`timescale 1ns/1ps
// Bench for conv_window_addr_gen: four parameterisations swept together against a queue scoreboard.
module tb_conv_window_addr_gen;
    localparam int AW = 32;
    localparam int NT = 25;
    localparam int VW = NT * AW;
    localparam int MAXW = 1352;
`ifdef CONV_ADDR_PAD_EN
    localparam int PADV = 2;
`else
    localparam int PADV = 0;
`endif

    logic clk = 1'b0;
    logic rst, start, pause, out_ready;
    always #5 clk = ~clk;

    logic          ov[4];
    logic [VW-1:0] ad[4];
    logic [NT-1:0] tm[4];
    logic [15:0]   wr[4], wc[4], wch[4];
    logic          ls[4], bz[4], dn[4];

    conv_window_addr_gen u0 (.clk(clk), .rst(rst), .start(start), .pause(pause), .out_ready(out_ready),
        .out_valid(ov[0]), .addr_out(ad[0]), .tap_mask(tm[0]), .win_row(wr[0]), .win_col(wc[0]),
        .win_ch(wch[0]), .last(ls[0]), .busy(bz[0]), .done(dn[0]));
    conv_window_addr_gen #(.STRIDE(2)) u1 (.clk(clk), .rst(rst), .start(start), .pause(pause), .out_ready(out_ready),
        .out_valid(ov[1]), .addr_out(ad[1]), .tap_mask(tm[1]), .win_row(wr[1]), .win_col(wc[1]),
        .win_ch(wch[1]), .last(ls[1]), .busy(bz[1]), .done(dn[1]));
    conv_window_addr_gen #(.NUM_CH(2)) u2 (.clk(clk), .rst(rst), .start(start), .pause(pause), .out_ready(out_ready),
        .out_valid(ov[2]), .addr_out(ad[2]), .tap_mask(tm[2]), .win_row(wr[2]), .win_col(wc[2]),
        .win_ch(wch[2]), .last(ls[2]), .busy(bz[2]), .done(dn[2]));
    conv_window_addr_gen #(.PAD(2)) u3 (.clk(clk), .rst(rst), .start(start), .pause(pause), .out_ready(out_ready),
        .out_valid(ov[3]), .addr_out(ad[3]), .tap_mask(tm[3]), .win_row(wr[3]), .win_col(wc[3]),
        .win_ch(wch[3]), .last(ls[3]), .busy(bz[3]), .done(dn[3]));

    typedef struct {
        logic [VW-1:0] addr;
        logic [NT-1:0] mask;
        int            row, col, ch;
        logic          last;
    } win_t;

    typedef struct {
        int k, idx, t0, t24, row, col, ch;
        logic last;
    } vec_t;

    win_t q0[$], q1[$], q2[$], q3[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    int   xfer_n[4]   = '{0, 0, 0, 0};
    int   done_n[4]   = '{0, 0, 0, 0};
    int   first_xc[4] = '{0, 0, 0, 0};
    int   last_xc[4]  = '{0, 0, 0, 0};
    int   base_x[4], base_d[4];
    logic          p_hold[4] = '{0, 0, 0, 0};
    logic          p_xfer[4] = '{0, 0, 0, 0};
    logic          p_last[4] = '{0, 0, 0, 0};
    logic [VW-1:0] p_addr[4];
    logic          p_pause = 1'b0;
    bit            cap_en  = 1'b0;

    int            cap_t0[4][MAXW], cap_t12[4][MAXW], cap_t24[4][MAXW];
    int            cap_row[4][MAXW], cap_col[4][MAXW], cap_ch[4][MAXW];
    logic          cap_last[4][MAXW];
    logic [NT-1:0] cap_mask[4][MAXW];

    win_t ck_e;
    bit   ck_xf;

    function automatic int stride_of(int k); return (k == 1) ? 2 : 1; endfunction
    function automatic int nch_of(int k);    return (k == 2) ? 2 : 1; endfunction
    function automatic int pad_of(int k);    return (k == 3) ? PADV : 0; endfunction
    function automatic int ow_of(int k);     return (30 + 2 * pad_of(k) - 5) / stride_of(k) + 1; endfunction
    function automatic int cnt_of(int k);    return nch_of(k) * ow_of(k) * ow_of(k); endfunction

    function automatic win_t model(int k, int ch, int row, int col);
        win_t w;
        int   s, p, y, x;
        s      = stride_of(k);
        p      = pad_of(k);
        w.addr = '0;
        w.mask = '0;
        w.row  = row;
        w.col  = col;
        w.ch   = ch;
        w.last = (ch == nch_of(k) - 1) && (row == ow_of(k) - 1) && (col == ow_of(k) - 1);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                y = row * s - p + r;
                x = col * s - p + c;
                if (y >= 0 && y < 30 && x >= 0 && x < 30) begin
                    w.addr[(r*5+c)*AW +: AW] = AW'(ch * 900 + y * 30 + x);
                    w.mask[r*5+c]            = 1'b1;
                end
            end
        end
        return w;
    endfunction

    function automatic int qsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic chk(input bit ok, input string name, input string info);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, info);
        end
    endtask

    task automatic push_all();
        win_t w;
        for (int k = 0; k < 4; k++)
            for (int ch = 0; ch < nch_of(k); ch++)
                for (int row = 0; row < ow_of(k); row++)
                    for (int col = 0; col < ow_of(k); col++) begin
                        w = model(k, ch, row, col);
                        case (k)
                            0:       q0.push_back(w);
                            1:       q1.push_back(w);
                            2:       q2.push_back(w);
                            default: q3.push_back(w);
                        endcase
                    end
    endtask

    task automatic mark_phase();
        for (int k = 0; k < 4; k++) begin
            base_x[k] = xfer_n[k];
            base_d[k] = done_n[k];
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_all_done(input int budget, input string tag);
        bit all_d;
        int i;
        all_d = 1'b0;
        i     = 0;
        while (!all_d && i < budget) begin
            @(posedge clk);
            i++;
            all_d = 1'b1;
            for (int k = 0; k < 4; k++) if (done_n[k] <= base_d[k]) all_d = 1'b0;
        end
        chk(all_d, {tag, "_finish"}, $sformatf("all sweeps done=%0b after %0d cycles, want 1", all_d, i));
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk(xfer_n[k] - base_x[k] == cnt_of(k), {tag, "_count"},
                $sformatf("u%0d transfers %0d want %0d", k, xfer_n[k] - base_x[k], cnt_of(k)));
            chk(done_n[k] - base_d[k] == 1, {tag, "_done_once"},
                $sformatf("u%0d done pulses %0d want 1", k, done_n[k] - base_d[k]));
            chk(qsize(k) == 0 && bz[k] == 1'b0, {tag, "_drained"},
                $sformatf("u%0d left %0d busy=%b want 0 0", k, qsize(k), bz[k]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 4; k++)
            chk(ov[k] == 1'b0 && bz[k] == 1'b0 && dn[k] == 1'b0 && ls[k] == 1'b0 && ad[k] == '0 &&
                tm[k] == '0 && wr[k] == 16'd0 && wc[k] == 16'd0 && wch[k] == 16'd0, tag,
                $sformatf("u%0d valid=%b busy=%b done=%b last=%b mask=%h tap0=%0d want all 0",
                          k, ov[k], bz[k], dn[k], ls[k], tm[k], ad[k][AW-1:0]));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (p_hold[k])
                chk(ov[k] && ad[k] == p_addr[k], "stall_hold",
                    $sformatf("u%0d valid=%b tap0=%0d want valid=1 tap0=%0d", k, ov[k], ad[k][AW-1:0], p_addr[k][AW-1:0]));
            if (p_xfer[k] && !p_last[k])
                chk(ov[k] == !p_pause, "valid_after_xfer",
                    $sformatf("u%0d valid=%b want %b (pause=%b)", k, ov[k], !p_pause, p_pause));
            if (dn[k] === 1'b1) begin
                done_n[k]++;
                chk(cyc == last_xc[k] + 1, "done_timing",
                    $sformatf("u%0d done at cycle %0d want %0d", k, cyc, last_xc[k] + 1));
            end
            ck_xf = (ov[k] === 1'b1) && out_ready && !rst;
            if (ck_xf) begin
                if (qsize(k) == 0) begin
                    chk(1'b0, "unexpected_window", $sformatf("u%0d window %0d/%0d/%0d with empty scoreboard, want none",
                                                            k, wch[k], wr[k], wc[k]));
                end else begin
                    case (k)
                        0:       ck_e = q0.pop_front();
                        1:       ck_e = q1.pop_front();
                        2:       ck_e = q2.pop_front();
                        default: ck_e = q3.pop_front();
                    endcase
                    chk(ad[k] == ck_e.addr && tm[k] == ck_e.mask && ls[k] == ck_e.last && int'(wr[k]) == ck_e.row &&
                        int'(wc[k]) == ck_e.col && int'(wch[k]) == ck_e.ch, "window",
                        $sformatf("u%0d got %0d/%0d/%0d tap0=%0d tap24=%0d mask=%h last=%b, want %0d/%0d/%0d tap0=%0d tap24=%0d mask=%h last=%b",
                                  k, wch[k], wr[k], wc[k], ad[k][AW-1:0], ad[k][24*AW +: AW], tm[k], ls[k],
                                  ck_e.ch, ck_e.row, ck_e.col, ck_e.addr[AW-1:0], ck_e.addr[24*AW +: AW], ck_e.mask, ck_e.last));
                end
                if (xfer_n[k] == 0) first_xc[k] = cyc;
                if (cap_en && xfer_n[k] < MAXW) begin
                    cap_t0[k][xfer_n[k]]   = int'(ad[k][AW-1:0]);
                    cap_t12[k][xfer_n[k]]  = int'(ad[k][12*AW +: AW]);
                    cap_t24[k][xfer_n[k]]  = int'(ad[k][24*AW +: AW]);
                    cap_row[k][xfer_n[k]]  = int'(wr[k]);
                    cap_col[k][xfer_n[k]]  = int'(wc[k]);
                    cap_ch[k][xfer_n[k]]   = int'(wch[k]);
                    cap_last[k][xfer_n[k]] = ls[k];
                    cap_mask[k][xfer_n[k]] = tm[k];
                end
                xfer_n[k]++;
                last_xc[k] = cyc;
            end
            p_hold[k] = (ov[k] === 1'b1) && !out_ready && !rst;
            p_addr[k] = ad[k];
            p_xfer[k] = ck_xf;
            p_last[k] = ls[k];
        end
        p_pause = pause;
    end

    initial begin
        vec_t vt[8];
        int   i;
        vt[0] = '{0, 0,    0,    124,  0,  0,  0, 1'b0};
        vt[1] = '{0, 675,  775,  899,  25, 25, 0, 1'b1};
        vt[2] = '{1, 1,    2,    126,  0,  1,  0, 1'b0};
        vt[3] = '{1, 13,   60,   184,  1,  0,  0, 1'b0};
        vt[4] = '{1, 168,  744,  868,  12, 12, 0, 1'b1};
        vt[5] = '{2, 675,  775,  899,  25, 25, 0, 1'b0};
        vt[6] = '{2, 676,  900,  1024, 0,  0,  1, 1'b0};
        vt[7] = '{2, 1351, 1675, 1799, 25, 25, 1, 1'b1};

        rst = 1'b1; start = 1'b0; pause = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("reset_state");

        // Free-running sweep with a stray start while busy.
        mark_phase();
        push_all();
        cap_en    = 1'b1;
        out_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        chk(ov[0] && bz[0], "first_valid_latency", $sformatf("valid=%b busy=%b want 1 1", ov[0], bz[0]));
        repeat (50) @(posedge clk);
        pulse_start();
        wait_all_done(3000, "sweep");
        cap_en = 1'b0;
        chk(last_xc[0] - first_xc[0] == 675, "back_to_back",
            $sformatf("u0 span %0d cycles want 675", last_xc[0] - first_xc[0]));

        foreach (vt[n]) begin
            chk(cap_t0[vt[n].k][vt[n].idx] == vt[n].t0 && cap_t24[vt[n].k][vt[n].idx] == vt[n].t24 &&
                cap_row[vt[n].k][vt[n].idx] == vt[n].row && cap_col[vt[n].k][vt[n].idx] == vt[n].col &&
                cap_ch[vt[n].k][vt[n].idx] == vt[n].ch && cap_last[vt[n].k][vt[n].idx] == vt[n].last, "spot",
                $sformatf("u%0d #%0d got t0=%0d t24=%0d rc=%0d,%0d ch=%0d last=%b want t0=%0d t24=%0d rc=%0d,%0d ch=%0d last=%b",
                          vt[n].k, vt[n].idx, cap_t0[vt[n].k][vt[n].idx], cap_t24[vt[n].k][vt[n].idx],
                          cap_row[vt[n].k][vt[n].idx], cap_col[vt[n].k][vt[n].idx], cap_ch[vt[n].k][vt[n].idx],
                          cap_last[vt[n].k][vt[n].idx], vt[n].t0, vt[n].t24, vt[n].row, vt[n].col, vt[n].ch, vt[n].last));
        end
`ifdef CONV_ADDR_PAD_EN
        chk(cap_mask[3][0][11:0] == 12'h000 && cap_mask[3][0][12] == 1'b1 && cap_t12[3][0] == 0 && cap_t0[3][0] == 0,
            "pad_first", $sformatf("mask=%h tap12=%0d tap0=%0d want mask[12:0]=1000 tap12=0 tap0=0",
                                   cap_mask[3][0], cap_t12[3][0], cap_t0[3][0]));
        chk(cap_mask[3][899][24:13] == 12'h000 && cap_row[3][899] == 29 && cap_col[3][899] == 29, "pad_last",
            $sformatf("mask=%h rc=%0d,%0d want mask[24:13]=0 rc=29,29", cap_mask[3][899], cap_row[3][899], cap_col[3][899]));
`endif

        // Backpressure: fixed 5-cycle ready gap, then random ready/pause.
        mark_phase();
        push_all();
        pulse_start();
        i = 0;
        while (i < 12000 && (done_n[2] <= base_d[2] || done_n[0] <= base_d[0] ||
                             done_n[1] <= base_d[1] || done_n[3] <= base_d[3])) begin
            @(posedge clk);
            #1;
            if (i >= 40 && i < 45) out_ready = 1'b0;
            else                   out_ready = ($urandom_range(0, 3) != 0);
            pause = ($urandom_range(0, 5) == 0);
            i++;
        end
        pause     = 1'b0;
        out_ready = 1'b1;
        wait_all_done(100, "stall");

        // Abort mid-sweep with reset, then restart.
        mark_phase();
        push_all();
        pulse_start();
        i = 0;
        while (xfer_n[0] - base_x[0] < 100 && i < 1000) begin
            @(posedge clk);
            i++;
        end
        chk(xfer_n[0] - base_x[0] == 100, "abort_point", $sformatf("u0 transfers %0d want 100", xfer_n[0] - base_x[0]));
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("abort_outputs");
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        repeat (5) @(posedge clk);
        for (int k = 0; k < 4; k++)
            chk(done_n[k] == base_d[k], "abort_no_done", $sformatf("u%0d done pulses %0d want 0", k, done_n[k] - base_d[k]));
        mark_phase();
        push_all();
        pulse_start();
        wait_all_done(3000, "restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
